// File: rtl/cpu_pkg.sv
// Shared types and constants for the processor control unit: opcodes, FSM
// state encoding, ALU select values and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  // Values double as the OutState debug encoding.
  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    NOOP_S  = 4'd3,
    LOAD_A  = 4'd4,
    LOAD_B  = 4'd5,
    STORE_S = 4'd6,
    ADD_S   = 4'd7,
    SUB_S   = 4'd8,
    HALT_S  = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int OPC_LSB  = 12;
  localparam int ADDR_LSB = 4;
  localparam int RA_LSB   = 0;
  localparam int RB_LSB   = 8;
  localparam int RC_LSB   = 4;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of the 16-bit instruction word into opcode, memory
// address and register-file operand fields.
module ir_field_decode
  import cpu_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic [15:0]        ir,
  output opcode_e            opcode,
  output logic [DADDR_W-1:0] addr,
  output logic [RADDR_W-1:0] ra,
  output logic [RADDR_W-1:0] rb,
  output logic [RADDR_W-1:0] rc
);

  // Undefined opcodes pass through unchanged; the FSM treats them as NOOP.
  assign opcode = opcode_e'(ir[OPC_LSB +: 4]);
  assign addr   = ir[ADDR_LSB +: DADDR_W];
  assign ra     = ir[RA_LSB +: RADDR_W];
  assign rb     = ir[RB_LSB +: RADDR_W];
  assign rc     = ir[RC_LSB +: RADDR_W];

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing Moore FSM: fetch, decode and per-class execute control.
// Optional retired-instruction counter enabled by defining CONTROL_RETIRE_CNT_EN.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic [15:0]        IR,
  output logic               IR_ld,
  output logic               PC_up,
  output logic               PC_clr,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_addr,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_Ra_addr,
  output logic [RADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]         ALU_s0,
`ifdef CONTROL_RETIRE_CNT_EN
  output logic [15:0]        Retired,
`endif
  output logic [3:0]         OutState
);

  state_e             state, state_nxt;
  opcode_e            opcode;
  logic [DADDR_W-1:0] addr;
  logic [RADDR_W-1:0] ra, rb, rc;

  ir_field_decode #(
    .DADDR_W (DADDR_W),
    .RADDR_W (RADDR_W)
  ) u_decode (
    .ir     (IR),
    .opcode (opcode),
    .addr   (addr),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = INIT;
    case (state)
      INIT:    state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_STORE: state_nxt = STORE_S;
          OP_LOAD:  state_nxt = LOAD_A;
          OP_ADD:   state_nxt = ADD_S;
          OP_SUB:   state_nxt = SUB_S;
          OP_HALT:  state_nxt = HALT_S;
          default:  state_nxt = NOOP_S;
        endcase
      end
      NOOP_S:  state_nxt = FETCH;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = FETCH;
      STORE_S: state_nxt = FETCH;
      ADD_S:   state_nxt = FETCH;
      SUB_S:   state_nxt = FETCH;
      HALT_S:  state_nxt = HALT_S;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    IR_ld      = 1'b0;
    PC_up      = 1'b0;
    PC_clr     = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (state)
      INIT:  PC_clr = 1'b1;
      FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // LOAD_A gives the synchronous data memory a cycle before write-back.
      LOAD_A: begin
        D_addr    = addr;
        RF_s      = 1'b1;
        RF_W_addr = ra;
      end
      LOAD_B: begin
        D_addr    = addr;
        RF_s      = 1'b1;
        RF_W_addr = ra;
        RF_W_en   = 1'b1;
      end
      STORE_S: begin
        D_addr     = addr;
        RF_Ra_addr = ra;
        D_wr       = 1'b1;
      end
      ADD_S, SUB_S: begin
        RF_Ra_addr = rb;
        RF_Rb_addr = rc;
        RF_W_addr  = ra;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == ADD_S) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign OutState = state;

`ifdef CONTROL_RETIRE_CNT_EN
  logic retire;

  // Every execute state returns to FETCH unconditionally.
  assign retire = (state == NOOP_S) || (state == LOAD_B) || (state == STORE_S) ||
                  (state == ADD_S)  || (state == SUB_S);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)     Retired <= '0;
    else if (retire) Retired <= Retired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: acts as the IR register, steps each
// instruction class and checks state and outputs against hand-computed values.
module tb_control_fsm;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [15:0] IR;
  logic        IR_ld, PC_up, PC_clr, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
  logic [2:0]  ALU_s0;
`ifdef CONTROL_RETIRE_CNT_EN
  logic [15:0] Retired;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  control_fsm dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .IR         (IR),
    .IR_ld      (IR_ld),
    .PC_up      (PC_up),
    .PC_clr     (PC_clr),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
`ifdef CONTROL_RETIRE_CNT_EN
    .Retired    (Retired),
`endif
    .OutState   (OutState)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b0, IR_ld, PC_up, PC_clr, D_addr, D_wr, RF_s, RF_W_addr,
            RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
  endfunction

  task automatic run_noop();
    IR = 16'h0000;
    tick(); check("noop_decode", OutState, 2);
    tick(); check("noop_exec", OutState, 3);
    tick(); check("noop_fetch", OutState, 1);
  endtask

  initial begin
    ResetN = 1'b0;
    IR     = 16'h0000;
    tick(); tick();
    check("rst_state", OutState, 0);
    check("rst_pc_clr", PC_clr, 1);
    check("rst_pc_up", PC_up, 0);

    ResetN = 1'b1;
    tick();
    check("fetch_state", OutState, 1);
    check("fetch_ir_ld", IR_ld, 1);
    check("fetch_pc_up", PC_up, 1);
    check("fetch_pc_clr", PC_clr, 0);

    // LOAD 0x2A53
    IR = 16'h2A53;
    tick();
    check("ld_decode", OutState, 2);
    check("ld_decode_outs", all_outs(), 0);
    tick();
    check("ld_a_state", OutState, 4);
    check("ld_a_daddr", D_addr, 8'hA5);
    check("ld_a_waddr", RF_W_addr, 3);
    check("ld_a_rfs", RF_s, 1);
    check("ld_a_wen", RF_W_en, 0);
    check("ld_a_ir_ld", IR_ld, 0);
    tick();
    check("ld_b_state", OutState, 5);
    check("ld_b_wen", RF_W_en, 1);
    check("ld_b_daddr", D_addr, 8'hA5);
    tick();
    check("ld_back_fetch", OutState, 1);
    check("ld_back_wen", RF_W_en, 0);

    // STORE 0x1127
    IR = 16'h1127;
    tick();
    check("st_decode_wr", D_wr, 0);
    tick();
    check("st_state", OutState, 6);
    check("st_daddr", D_addr, 8'h12);
    check("st_ra", RF_Ra_addr, 7);
    check("st_dwr", D_wr, 1);
    check("st_wen", RF_W_en, 0);
    tick();
    check("st_fetch", OutState, 1);
    check("st_dwr_off", D_wr, 0);

    // ADD 0x3124
    IR = 16'h3124;
    tick(); tick();
    check("add_state", OutState, 7);
    check("add_ra", RF_Ra_addr, 1);
    check("add_rb", RF_Rb_addr, 2);
    check("add_wa", RF_W_addr, 4);
    check("add_alu", ALU_s0, 1);
    check("add_wen", RF_W_en, 1);
    check("add_dwr", D_wr, 0);
    tick();
    check("add_fetch", OutState, 1);

    // SUB 0x4124
    IR = 16'h4124;
    tick(); tick();
    check("sub_state", OutState, 8);
    check("sub_ra", RF_Ra_addr, 1);
    check("sub_rb", RF_Rb_addr, 2);
    check("sub_wa", RF_W_addr, 4);
    check("sub_alu", ALU_s0, 2);
    check("sub_wen", RF_W_en, 1);
    tick();
    check("sub_fetch", OutState, 1);

    // Undefined opcode 0xF000 executes as NOOP
    IR = 16'hF000;
    tick();
    tick();
    check("undef_noop_state", OutState, 3);
    check("undef_noop_outs", all_outs(), 0);
    tick();
    check("undef_fetch", OutState, 1);

`ifdef CONTROL_RETIRE_CNT_EN
    check("retired_5", Retired, 5);
`endif

    // HALT 0x5000
    IR = 16'h5000;
    tick(); tick();
    check("halt_state", OutState, 9);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_hold_state", OutState, 9);
      check("halt_hold_outs", all_outs(), 0);
    end

    // Asynchronous reset pulse between edges
    #2 ResetN = 1'b0;
    #1;
    check("async_rst_state", OutState, 0);
    check("async_rst_pc_clr", PC_clr, 1);
`ifdef CONTROL_RETIRE_CNT_EN
    check("async_rst_retired", Retired, 0);
`endif
    #1 ResetN = 1'b1;
    tick();
    check("post_rst_fetch", OutState, 1);

    run_noop();
    run_noop();
    run_noop();
`ifdef CONTROL_RETIRE_CNT_EN
    check("retired_3", Retired, 3);
`endif

    // Reset during LOAD_A abandons the write-back
    IR = 16'h2A53;
    tick(); tick();
    check("mid_ld_a", OutState, 4);
    #2 ResetN = 1'b0;
    #1;
    check("mid_rst_state", OutState, 0);
    check("mid_rst_wen", RF_W_en, 0);
`ifdef CONTROL_RETIRE_CNT_EN
    check("mid_rst_retired", Retired, 0);
`endif
    tick();
    check("mid_rst_hold_state", OutState, 0);
    check("mid_rst_hold_wen", RF_W_en, 0);
    ResetN = 1'b1;
    tick();
    check("mid_rst_refetch", OutState, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Instruction-sequencing control unit for the simple processor.
- Drives the Instruction Register's load strobe and the Program Counter during fetch.
- Consumes the latched 16-bit instruction, decodes it, and issues data-memory, register-file and ALU control for each instruction class.
- Sits between the IR/PC (fetch side) and the datapath (execute side).

Parameters:
- DADDR_W, 8, data-memory address width (instruction bits [11:4] for LOAD/STORE)
- RADDR_W, 4, register-file address width

Ports:
- Clock  in  1  system clock, rising-edge active
- ResetN  in  1  asynchronous active-low reset
- IR  in  16  current instruction from the Instruction Register
- IR_ld  out  1  load strobe to the Instruction Register
- PC_up  out  1  increment Program Counter
- PC_clr  out  1  clear Program Counter
- D_addr  out  8  data-memory address
- D_wr  out  1  data-memory write enable
- RF_s  out  1  register-file write-data select (1 = memory, 0 = ALU)
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file read port A address
- RF_Rb_addr  out  4  register-file read port B address
- ALU_s0  out  3  ALU function select
- OutState  out  4  current state encoding, for debug display

Behaviour:
- Reset is one clock with an asynchronous, active-low reset; the clock port is Clock and the reset port is ResetN.
- ResetN low forces the state to INIT immediately, independent of Clock. This applies mid-instruction too; any pending write is abandoned.
- Moore outputs: every output is a function of state and IR fields only, with no combinational path from IR to state.
- Default for every output is 0 unless stated below.
- Opcode is IR[15:12]:
  - NOOP = 0
  - STORE = 1
  - LOAD = 2
  - ADD = 3
  - SUB = 4
  - HALT = 5
  - 6–15 are undefined and execute as NOOP.
- Instruction fields:
  - LOAD/STORE: addr = IR[11:4], Ra = IR[3:0].
  - ADD/SUB: Rb = IR[11:8], Rc = IR[7:4], Ra = IR[3:0] (destination).
- States and outputs:
  - INIT: PC_clr = 1. Next state is FETCH. This is the state during and on release of reset.
  - FETCH: IR_ld = 1, PC_up = 1. Next state is DECODE; IR holds the new instruction from the next cycle.
  - DECODE: all outputs 0. Branches on opcode to NOOP_S, LOAD_A, STORE_S, ADD_S, SUB_S or HALT_S.
  - NOOP_S: next state is FETCH.
  - LOAD_A: D_addr = addr, RF_s = 1, RF_W_addr = Ra. Next state is LOAD_B, covering one cycle of synchronous memory read latency.
  - LOAD_B: same outputs as LOAD_A plus RF_W_en = 1. Next state is FETCH.
  - STORE_S: D_addr = addr, RF_Ra_addr = Ra, D_wr = 1. Next state is FETCH.
  - ADD_S: RF_Ra_addr = Rb, RF_Rb_addr = Rc, RF_W_addr = Ra, RF_W_en = 1, ALU_s0 = ALU_ADD. Next state is FETCH.
  - SUB_S: same as ADD_S with ALU_s0 = ALU_SUB.
  - HALT_S: all outputs 0. Stays in HALT_S until ResetN is asserted.
- Instruction latencies: NOOP/ADD/SUB/STORE take 3 cycles (FETCH, DECODE, execute); LOAD takes 4.
- IR_ld and PC_up are asserted in exactly one cycle per instruction.
- PC_clr is never asserted together with PC_up.
- D_wr and RF_W_en are never asserted together.
- OutState encoding: INIT = 0, FETCH = 1, DECODE = 2, NOOP_S = 3, LOAD_A = 4, LOAD_B = 5, STORE_S = 6, ADD_S = 7, SUB_S = 8, HALT_S = 9.
- An illegal state register value goes to INIT on the next clock edge.

Optional Feature:
- Macro: CONTROL_RETIRE_CNT_EN.
- When defined:
  - Adds output Retired (16 bits), reset to 0.
  - Retired increments on every transition into FETCH from an execute state (NOOP_S, LOAD_B, STORE_S, ADD_S, SUB_S).
  - It wraps from 0xFFFF to 0.
  - It holds in HALT_S and clears on ResetN.
- When undefined: no port, no counter logic, and behaviour is otherwise identical.

Decomposition:
- Package cpu_pkg holds:
  - the opcode enum (4-bit);
  - the state enum (4-bit, explicit values listed above);
  - ALU select constants: ALU_PASS = 0, ALU_ADD = 1, ALU_SUB = 2;
  - field bit-position localparams.
- One natural sub-module, ir_field_decode: a purely combinational split of IR into opcode, addr, Ra, Rb and Rc.
- The FSM stays in control_fsm.

Test Plan:
- Reset and fetch: ResetN = 0 with Clock running gives OutState = 0 and PC_clr = 1. After release, the next cycle gives OutState = 1 with IR_ld = 1 and PC_up = 1.
- LOAD: IR = 0x2A53 → D_addr = 0xA5 and RF_W_addr = 3 in LOAD_A. RF_W_en = 1 only in LOAD_B. Back in FETCH 4 cycles after the previous FETCH.
- STORE: IR = 0x1127 → D_addr = 0x12, RF_Ra_addr = 7, D_wr = 1 for exactly one cycle, RF_W_en = 0 throughout.
- ADD then SUB:
  - IR = 0x3124 → RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 4, ALU_s0 = 1, RF_W_en = 1.
  - IR = 0x4124 → same addresses with ALU_s0 = 2.
- HALT and undefined opcode:
  - IR = 0xF000 takes the NOOP path and returns to FETCH.
  - IR = 0x5000 reaches HALT_S and stays there for 20 cycles with all outputs 0.
  - Asynchronous ResetN pulse mid-cycle gives OutState = 0 immediately.
- Reset mid-operation (with CONTROL_RETIRE_CNT_EN):
  - Retired = 3 after three NOOPs.
  - Asserting ResetN during LOAD_A gives no RF_W_en, Retired = 0 and state INIT.
